// File: rtl/rf_ctrl_pkg.sv
// Shared op/FunSel codes, register codes, FSM states and select decode for the register-file sequencer.
// Register codes 0-3 select T1-T4 and 4-7 select R1-R4; the lowest code of each bank maps to select bit 3.
package rf_ctrl_pkg;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_COPY = 3'b100;
  localparam logic [2:0] OP_READ = 3'b101;
  localparam logic [2:0] OP_INCN = 3'b110;
  localparam logic [2:0] OP_DECN = 3'b111;

  localparam logic [1:0] FS_CLR  = 2'b00;
  localparam logic [1:0] FS_LOAD = 2'b01;
  localparam logic [1:0] FS_DEC  = 2'b10;
  localparam logic [1:0] FS_INC  = 2'b11;

  localparam logic [2:0] CODE_T1 = 3'd0;
  localparam logic [2:0] CODE_T2 = 3'd1;
  localparam logic [2:0] CODE_T3 = 3'd2;
  localparam logic [2:0] CODE_T4 = 3'd3;
  localparam logic [2:0] CODE_R1 = 3'd4;
  localparam logic [2:0] CODE_R2 = 3'd5;
  localparam logic [2:0] CODE_R3 = 3'd6;
  localparam logic [2:0] CODE_R4 = 3'd7;

  typedef enum logic [2:0] {IDLE, EXEC, REPEAT, FETCH, WRITE, CAPT} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] dst;
  } cmd_t;

  // Returns {RSel, TSel} with exactly one bit set.
  function automatic logic [7:0] code_to_sel(input logic [2:0] code);
    logic [3:0] onehot;
    onehot = 4'b1000 >> code[1:0];
    return code[2] ? {onehot, 4'b0000} : {4'b0000, onehot};
  endfunction

endpackage

// File: rtl/rf_sel_decoder.sv
// Register code to RSel/TSel one-hot decode, combinational; all-zero when disabled.
module rf_sel_decoder
  import rf_ctrl_pkg::*;
(
  input  logic [2:0] code,
  input  logic       en,
  output logic [3:0] rsel,
  output logic [3:0] tsel
);

  assign {rsel, tsel} = en ? code_to_sel(code) : 8'h00;

endmodule

// File: rtl/regfile_sequencer.sv
// Turns register commands into per-cycle register-file control words; 2-3 cycles per op, cnt+1 for repeats.
// Accepts only in IDLE (cmd_ready); READ responses are single-cycle pulses with no backpressure.
module regfile_sequencer
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_dst,
  input  logic [2:0] cmd_src,
  input  logic [7:0] cmd_imm,
  input  logic [3:0] cmd_cnt,
  output logic [7:0] rf_I,
  output logic [1:0] rf_FunSel,
  output logic [3:0] rf_RSel,
  output logic [3:0] rf_TSel,
  output logic [2:0] rf_O1Sel,
  output logic [2:0] rf_O2Sel,
  input  logic [7:0] rf_O1,
  input  logic [2:0] mon_sel,
  output logic       rsp_valid,
  output logic [7:0] rsp_data
);

  state_t     state;
  cmd_t       cmd_q;
  logic [3:0] rep_cnt;
  logic [7:0] i_q;
  logic [2:0] dec_code;
  logic       dec_en;
  logic [3:0] dec_rsel;
  logic [3:0] dec_tsel;
  logic       accept;
  logic       done;

  assign accept = cmd_valid && cmd_ready;

  // While idle the incoming command is decoded; afterwards the latched destination.
  assign dec_code = cmd_ready ? cmd_dst : cmd_q.dst;
  assign dec_en   = !(cmd_ready && (cmd_op[2:1] == 2'b11) && (cmd_cnt == 4'd0));

  rf_sel_decoder u_dst_dec (
    .code (dec_code),
    .en   (dec_en),
    .rsel (dec_rsel),
    .tsel (dec_tsel)
  );

  assign done = (state == EXEC) || (state == WRITE) || (state == CAPT) ||
                ((state == REPEAT) && (rep_cnt == 4'd0));

  // WRITE forwards the registered O1 readback straight into the data bus.
  assign rf_I     = (state == WRITE) ? rf_O1 : i_q;
  assign rf_O2Sel = mon_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_q     <= '0;
      rep_cnt   <= 4'd0;
      i_q       <= 8'h00;
      cmd_ready <= 1'b1;
      rf_FunSel <= FS_CLR;
      rf_RSel   <= 4'b0000;
      rf_TSel   <= 4'b0000;
      rf_O1Sel  <= 3'b000;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q     <= '{op: cmd_op, dst: cmd_dst};
            cmd_ready <= 1'b0;
            case (cmd_op)
              OP_COPY, OP_READ: begin
                state    <= FETCH;
                rf_O1Sel <= cmd_src;
              end
              OP_INCN, OP_DECN: begin
                rf_RSel <= dec_rsel;
                rf_TSel <= dec_tsel;
                if (cmd_cnt == 4'd0) begin
                  state     <= EXEC;
                  rf_FunSel <= FS_CLR;
                end else begin
                  state     <= REPEAT;
                  rep_cnt   <= cmd_cnt - 4'd1;
                  rf_FunSel <= (cmd_op == OP_INCN) ? FS_INC : FS_DEC;
                end
              end
              default: begin
                state     <= EXEC;
                rf_FunSel <= cmd_op[1:0];
                rf_RSel   <= dec_rsel;
                rf_TSel   <= dec_tsel;
                i_q       <= (cmd_op == OP_LOAD) ? cmd_imm : 8'h00;
              end
            endcase
          end
        end
        REPEAT: begin
          if (rep_cnt != 4'd0) begin
            rep_cnt <= rep_cnt - 4'd1;
          end
        end
        FETCH: begin
          if (cmd_q.op == OP_COPY) begin
            state     <= WRITE;
            rf_FunSel <= FS_LOAD;
            rf_RSel   <= dec_rsel;
            rf_TSel   <= dec_tsel;
          end else begin
            state <= CAPT;
          end
        end
        CAPT: begin
          rsp_data  <= rf_O1;
          rsp_valid <= 1'b1;
        end
        EXEC, WRITE: ;
        default: state <= IDLE;
      endcase

      if (done) begin
        state     <= IDLE;
        cmd_ready <= 1'b1;
        rf_FunSel <= FS_CLR;
        rf_RSel   <= 4'b0000;
        rf_TSel   <= 4'b0000;
        i_q       <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a register-file stand-in driven by the DUT, and a command-level model of
// the eight registers that predicts READ data, per-cycle control words and register contents.
module tb_regfile_sequencer;
  import rf_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [2:0] cmd_dst = 3'd0;
  logic [2:0] cmd_src = 3'd0;
  logic [7:0] cmd_imm = 8'h00;
  logic [3:0] cmd_cnt = 4'd0;
  logic [7:0] rf_I;
  logic [1:0] rf_FunSel;
  logic [3:0] rf_RSel;
  logic [3:0] rf_TSel;
  logic [2:0] rf_O1Sel;
  logic [2:0] rf_O2Sel;
  logic [7:0] rf_O1 = 8'h00;
  logic [2:0] mon_sel = 3'd0;
  logic       rsp_valid;
  logic [7:0] rsp_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] regs [8];
  logic [7:0] exp_regs [8];

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_src   (cmd_src),
    .cmd_imm   (cmd_imm),
    .cmd_cnt   (cmd_cnt),
    .rf_I      (rf_I),
    .rf_FunSel (rf_FunSel),
    .rf_RSel   (rf_RSel),
    .rf_TSel   (rf_TSel),
    .rf_O1Sel  (rf_O1Sel),
    .rf_O2Sel  (rf_O2Sel),
    .rf_O1     (rf_O1),
    .mon_sel   (mon_sel),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  // Expected {RSel, TSel} for a register code, straight from the register naming table.
  function automatic logic [7:0] exp_sel(input logic [2:0] code);
    logic [7:0] s;
    s = 8'h00;
    case (code)
      3'd0: s = 8'h08;
      3'd1: s = 8'h04;
      3'd2: s = 8'h02;
      3'd3: s = 8'h01;
      3'd4: s = 8'h80;
      3'd5: s = 8'h40;
      3'd6: s = 8'h20;
      3'd7: s = 8'h10;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Register file stand-in: O1 is registered, writes follow FunSel on selected registers.
  always @(posedge clk) begin
    logic [7:0] sel;
    sel = {rf_RSel, rf_TSel};
    rf_O1 <= regs[rf_O1Sel];
    for (int i = 0; i < 8; i++) begin
      if ((sel & exp_sel(3'(i))) != 8'h00) begin
        case (rf_FunSel)
          2'b00: regs[i] <= 8'h00;
          2'b01: regs[i] <= rf_I;
          2'b10: regs[i] <= regs[i] - 8'd1;
          default: regs[i] <= regs[i] + 8'd1;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) chk(tag, {24'h0, regs[i]}, {24'h0, exp_regs[i]});
  endtask

  // Issues one command at a negedge and follows it cycle by cycle until the first ready cycle.
  task automatic run(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                     input logic [7:0] imm, input logic [3:0] cnt, input bit noise);
    int n;
    int lat;
    int sel_cycles;
    int want_sel_cycles;
    logic [1:0] fs;
    logic [7:0] want;
    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm; cmd_cnt = cnt;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", {31'h0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = noise;
    if (noise) begin
      cmd_op = 3'($urandom); cmd_dst = 3'($urandom); cmd_src = 3'($urandom);
      cmd_imm = 8'($urandom); cmd_cnt = 4'($urandom);
    end

    want = exp_regs[src];
    fs = 2'b00;
    lat = 2;
    want_sel_cycles = 1;
    case (op)
      OP_CLR:  fs = 2'b00;
      OP_LOAD: fs = 2'b01;
      OP_DEC:  fs = 2'b10;
      OP_INC:  fs = 2'b11;
      OP_COPY: begin fs = 2'b01; lat = 3; end
      OP_READ: begin lat = 3; want_sel_cycles = 0; end
      OP_INCN: begin fs = 2'b11; lat = (cnt == 0) ? 2 : int'(cnt) + 1; want_sel_cycles = int'(cnt); end
      default: begin fs = 2'b10; lat = (cnt == 0) ? 2 : int'(cnt) + 1; want_sel_cycles = int'(cnt); end
    endcase

    sel_cycles = 0;
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      if (op == OP_READ) begin
        mon_sel = 3'($urandom);
        #1;
        chk("o2sel_follow", {29'h0, rf_O2Sel}, {29'h0, mon_sel});
      end
      chk("ready_timing", {31'h0, cmd_ready}, {31'h0, (j == lat)});
      if ({rf_RSel, rf_TSel} != 8'h00) begin
        sel_cycles++;
        chk("sel_decode", {24'h0, rf_RSel, rf_TSel}, {24'h0, exp_sel(dst)});
        chk("funsel", {30'h0, rf_FunSel}, {30'h0, fs});
      end
      if (op == OP_LOAD && j == 1) chk("load_data", {24'h0, rf_I}, {24'h0, imm});
      if (op == OP_COPY && j == 1) chk("fetch_o1sel", {29'h0, rf_O1Sel}, {29'h0, src});
      if (op == OP_COPY && j == 2) chk("copy_data", {24'h0, rf_I}, {24'h0, want});
      if (op == OP_READ && j == lat) begin
        chk("rsp_valid", {31'h0, rsp_valid}, 32'd1);
        chk("rsp_data", {24'h0, rsp_data}, {24'h0, want});
      end else begin
        chk("rsp_idle", {31'h0, rsp_valid}, 32'd0);
      end
    end
    cmd_valid = 1'b0;
    chk("sel_cycles", sel_cycles, want_sel_cycles);

    case (op)
      OP_CLR:  exp_regs[dst] = 8'h00;
      OP_LOAD: exp_regs[dst] = imm;
      OP_DEC:  exp_regs[dst] = exp_regs[dst] - 8'd1;
      OP_INC:  exp_regs[dst] = exp_regs[dst] + 8'd1;
      OP_COPY: exp_regs[dst] = want;
      OP_INCN: exp_regs[dst] = 8'((int'(exp_regs[dst]) + int'(cnt)) % 256);
      OP_DECN: exp_regs[dst] = 8'((int'(exp_regs[dst]) + 256 - int'(cnt)) % 256);
      default: ;
    endcase
    chk_regs("regs_after_cmd");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {31'h0, cmd_ready}, 32'd1);
    chk(tag, {24'h0, rf_I}, 32'h0);
    chk(tag, {30'h0, rf_FunSel}, 32'h0);
    chk(tag, {24'h0, rf_RSel, rf_TSel}, 32'h0);
    chk(tag, {29'h0, rf_O1Sel}, 32'h0);
    chk(tag, {31'h0, rsp_valid}, 32'h0);
    chk(tag, {24'h0, rsp_data}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      regs[i] = 8'h00;
      exp_regs[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    run(OP_LOAD, 3'd4, 3'd0, 8'h5A, 4'd0, 1'b0);
    run(OP_READ, 3'd0, 3'd4, 8'h00, 4'd0, 1'b0);

    run(OP_LOAD, 3'd1, 3'd0, 8'hFF, 4'd0, 1'b0);
    run(OP_INC,  3'd1, 3'd0, 8'h00, 4'd0, 1'b0);
    run(OP_READ, 3'd0, 3'd1, 8'h00, 4'd0, 1'b0);
    run(OP_DECN, 3'd1, 3'd0, 8'h00, 4'd3, 1'b0);
    run(OP_READ, 3'd0, 3'd1, 8'h00, 4'd0, 1'b0);

    run(OP_LOAD, 3'd6, 3'd0, 8'h33, 4'd0, 1'b0);
    run(OP_COPY, 3'd0, 3'd6, 8'h00, 4'd0, 1'b1);
    run(OP_INC,  3'd0, 3'd0, 8'h00, 4'd0, 1'b0);
    run(OP_COPY, 3'd6, 3'd6, 8'h00, 4'd0, 1'b0);
    run(OP_READ, 3'd0, 3'd6, 8'h00, 4'd0, 1'b0);
    run(OP_INCN, 3'd5, 3'd0, 8'h00, 4'd0, 1'b1);

    // Reset lands in the third REPEAT cycle: two increments have already happened.
    cmd_op = OP_INCN; cmd_dst = 3'd7; cmd_cnt = 4'd10; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_in_repeat");
    exp_regs[7] = exp_regs[7] + 8'd2;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("ready_after_reset", {31'h0, cmd_ready}, 32'd1);
    chk_regs("regs_after_reset");

    for (int k = 0; k < 80; k++) begin
      run(3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 4'($urandom),
          1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
